rs232_rx_deser: RTL and testbench
=================================

// Module: rs232_rx_deser
// PURPOSE
//  RS232 receive deserializer. It recovers bytes from the asynchronous rx line and hands them,
//  with parity/framing status, to the rs232_memory command decoder.
//  It sits directly between the rx pin and the decoder that parses cmd/addr/data byte sequences.
//  Frame format: 1 start (0), 8 data bits MSB first, 1 parity bit, 1 stop (1).
// PARAMETERS
//  RS232_RATIO  [19:0]  1736  clk cycles per bit period; minimum supported value is 4
//  PARITY       1 bit   1     expected parity bit = (^data) ^ PARITY (1 = odd, 0 = even)
// PORTS
//  clk         in   1  system clock
//  rst         in   1  reset; synchronous and active-high
//  rx          in   1  asynchronous serial input; idles high
//  data_out    out  8  last received byte; held until the next data_valid
//  data_valid  out  1  single-cycle pulse when a frame completes
//  parity_err  out  1  valid with data_valid; 1 = received parity bit mismatched
//  frame_err   out  1  valid with data_valid; 1 = stop bit sampled as 0
//  busy        out  1  high from start detection until the frame ends (not IDLE)
// BEHAVIOUR
//  - rx passes through a 2-FF synchronizer (rx_s). Both flops reset to 1, so reset never produces a false start.
//  - Reset values: data_out=8'h00; data_valid, parity_err, frame_err and busy = 0; FSM=IDLE; counters=0.
//  - Bit counter: 20-bit cnt; 4-bit bit index. Let T0 = first cycle rx_s==0 seen in IDLE.
//    Sample points are T0 + (RS232_RATIO>>1) + k*RS232_RATIO:
//    k=0 start, k=1..8 data, k=9 parity, k=10 stop.
//  - FSM states: IDLE, START, DATA, PAR, STOP, BREAK.
//    IDLE : rx_s==0 -> START, cnt=0.
//    START: at k=0 sample: rx_s==1 -> IDLE (glitch, no output); else -> DATA.
//    DATA : at each sample, shreg <= {shreg[6:0], rx_s} (MSB first). After 8 samples -> PAR.
//    PAR  : sample; perr = rx_s ^ (^shreg) ^ PARITY. -> STOP.
//    STOP : sample; next cycle: data_out=shreg, data_valid=1, parity_err=perr, frame_err=~rx_s.
//           rx_s==1 -> IDLE. This allows the next start bit half a bit period early.
//           rx_s==0 -> BREAK.
//    BREAK: wait for rx_s==1, then -> IDLE. No start detection in BREAK.
//  - A byte with a parity or framing error is still delivered with data_valid=1. The decoder discards it.
//  - parity_err/frame_err are meaningful only while data_valid=1; they are 0 otherwise.
//  - busy = (state != IDLE). BREAK counts as busy.
//  - Reset mid-frame: the frame is abandoned, with no data_valid and all outputs at reset values.
//    The next frame after reset is received normally.
//  - Back-to-back frames with zero idle between the stop bit and the next start bit are fully supported.
//  - Latency: data_valid occurs at T0 + (RS232_RATIO>>1) + 10*RS232_RATIO + 1.
//    T0 itself is 2 clk after the rx falling edge.
// TESTING  (run with RS232_RATIO=16 and with 1736; PARITY=1 unless noted)
//  1 Frame 0xA5, parity bit 1, stop 1 -> one data_valid pulse; data_out=A5; parity_err=0; frame_err=0;
//    pulse lands at the cycle given by the latency formula.
//  2 Frame 0x0F with inverted parity bit (0) -> data_valid; data_out=0F; parity_err=1; frame_err=0.
//  3 rx low for RS232_RATIO/4 cycles, then high -> no data_valid; busy drops back to 0;
//    a following frame 0x3C is received correctly.
//  4 Frame 0x8A with stop bit 0, then rx held low 3 bit times -> data_valid with frame_err=1;
//    no further data_valid until rx returns high; a later frame 0x11 is received correctly.
//  5 Back-to-back 0xC0, 0x12, 0x8A (zero idle), PARITY=0 build too -> exactly 3 pulses, in order,
//    with no errors.
//  6 rst asserted 1 cycle after the 4th data bit of 0xF1 -> outputs 0 with no pulse;
//    the next frame 0x5A gives data_out=5A with no errors.

Source files
------------

// File: rtl/rs232_rx_deser.sv
// ---------------------------------------------------------------------------
// rs232_rx_deser
//
// RS232 receive deserializer. Recovers bytes from the asynchronous rx line and
// hands them, with parity and framing status, to the command decoder.
// Frame: 1 start bit (0), 8 data bits MSB first, 1 parity bit, 1 stop bit (1).
//
// Parameters
//   RS232_RATIO : clk cycles per bit period (minimum 4)
//   PARITY      : expected parity bit = (^data) ^ PARITY (1 = odd, 0 = even)
//
// Ports
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   rx         in   asynchronous serial input, idles high
//   data_out   out  last received byte, held until the next data_valid
//   data_valid out  single-cycle pulse when a frame completes
//   parity_err out  with data_valid: received parity bit mismatched
//   frame_err  out  with data_valid: stop bit sampled as 0
//   busy       out  high whenever the receiver is not idle (BREAK included)
// ---------------------------------------------------------------------------
module rs232_rx_deser #(
    parameter logic [19:0] RS232_RATIO = 20'd1736,
    parameter logic        PARITY      = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    // The first sample lands half a bit after start detection; every later
    // sample lands one full bit after the previous one. The counter restarts
    // from zero at each sample, so the compare value depends on the state.
    localparam logic [19:0] HALF_M1 = (RS232_RATIO >> 1) - 20'd1;
    localparam logic [19:0] FULL_M1 = RS232_RATIO - 20'd1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP,
        BREAK
    } state_t;

    state_t      state_q, state_d;
    logic        sync1_q;
    logic        rx_s_q;
    logic [19:0] cnt_q, cnt_d;
    logic [3:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shreg_q, shreg_d;
    logic        perr_q, perr_d;
    logic [7:0]  data_out_q, data_out_d;
    logic        valid_q, valid_d;
    logic        parity_err_q, parity_err_d;
    logic        frame_err_q, frame_err_d;
    logic        sample;

    // Synchronizer flops reset to the idle level so reset never looks like a
    // start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
        end else begin
            sync1_q <= rx;
            rx_s_q  <= sync1_q;
        end
    end

    assign sample = (state_q == START) ? (cnt_q == HALF_M1) : (cnt_q == FULL_M1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= 20'd0;
            bit_idx_q    <= 4'd0;
            shreg_q      <= 8'h00;
            perr_q       <= 1'b0;
            data_out_q   <= 8'h00;
            valid_q      <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            shreg_q      <= shreg_d;
            perr_q       <= perr_d;
            data_out_q   <= data_out_d;
            valid_q      <= valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + 20'd1;
        bit_idx_d    = bit_idx_q;
        shreg_d      = shreg_q;
        perr_d       = perr_q;
        data_out_d   = data_out_q;
        // Status flags are only meaningful alongside the valid pulse.
        valid_d      = 1'b0;
        parity_err_d = 1'b0;
        frame_err_d  = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = 20'd0;
                if (!rx_s_q) begin
                    state_d   = START;
                    bit_idx_d = 4'd0;
                end
            end
            START: begin
                if (sample) begin
                    cnt_d = 20'd0;
                    // Line back high at mid start bit: treat as a glitch.
                    state_d = rx_s_q ? IDLE : DATA;
                end
            end
            DATA: begin
                if (sample) begin
                    cnt_d     = 20'd0;
                    shreg_d   = {shreg_q[6:0], rx_s_q};
                    bit_idx_d = bit_idx_q + 4'd1;
                    if (bit_idx_q == 4'd7) begin
                        state_d = PAR;
                    end
                end
            end
            PAR: begin
                if (sample) begin
                    cnt_d   = 20'd0;
                    perr_d  = rx_s_q ^ (^shreg_q) ^ PARITY;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (sample) begin
                    cnt_d        = 20'd0;
                    data_out_d   = shreg_q;
                    valid_d      = 1'b1;
                    parity_err_d = perr_q;
                    frame_err_d  = ~rx_s_q;
                    // Leaving at mid stop bit lets the next start bit be
                    // caught even with zero idle time between frames.
                    state_d      = rx_s_q ? IDLE : BREAK;
                end
            end
            BREAK: begin
                // Line held low after a bad stop bit: wait for idle level
                // before looking for another start bit.
                cnt_d = 20'd0;
                if (rx_s_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                cnt_d   = 20'd0;
                state_d = IDLE;
            end
        endcase
    end

    assign data_out   = data_out_q;
    assign data_valid = valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_rs232_rx_deser.sv
module tb_rs232_rx_deser;

    localparam int R    = 16;
    localparam int HALF = R >> 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx  = 1'b1;

    logic [7:0] do1, do0;
    logic       dv1, dv0, pe1, pe0, fe1, fe0, busy1, busy0;

    // Two receivers share the line: odd parity and even parity builds.
    rs232_rx_deser #(.RS232_RATIO(20'(R)), .PARITY(1'b1)) dut1 (
        .clk(clk), .rst(rst), .rx(rx),
        .data_out(do1), .data_valid(dv1), .parity_err(pe1),
        .frame_err(fe1), .busy(busy1)
    );

    rs232_rx_deser #(.RS232_RATIO(20'(R)), .PARITY(1'b0)) dut0 (
        .clk(clk), .rst(rst), .rx(rx),
        .data_out(do0), .data_valid(dv0), .parity_err(pe0),
        .frame_err(fe0), .busy(busy0)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        int         cyc_exp;
    } exp_t;

    exp_t q1[$];
    exp_t q0[$];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Scoreboard monitor: pops an expectation whenever a receiver pulses.
    task automatic mon(input int p, input logic dv, input logic [7:0] d,
                       input logic pe, input logic fe);
        exp_t e;
        if (dv) begin
            if ((p == 1 && q1.size() == 0) || (p == 0 && q0.size() == 0)) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse dut%0d: got data %02h at cycle %0d, required no pulse",
                         p, d, cyc);
            end else begin
                if (p == 1) e = q1.pop_front();
                else        e = q0.pop_front();
                $display("rx dut%0d: data=%02h perr=%0d ferr=%0d cycle=%0d", p, d, pe, fe, cyc);
                chk($sformatf("data_out dut%0d", p), d, e.data);
                chk($sformatf("parity_err dut%0d", p), pe, e.perr);
                chk($sformatf("frame_err dut%0d", p), fe, e.ferr);
                chk($sformatf("latency dut%0d", p), cyc, e.cyc_exp);
            end
        end else begin
            chk($sformatf("flags_idle dut%0d", p), {pe, fe}, 0);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            mon(1, dv1, do1, pe1, fe1);
            mon(0, dv0, do0, pe0, fe0);
        end
    end

    function automatic logic good_pb(input logic [7:0] d, input logic p);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        return logic'(ones % 2) ^ p;
    endfunction

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Sends one whole frame; expectations are derived from what is put on
    // the line: a parity error is flagged when the sent parity bit differs
    // from the correct one for that receiver's parity mode.
    task automatic send_frame(input logic [7:0] d, input logic pb, input logic sb);
        exp_t e;
        logic [10:0] bits;
        bits = {sb, pb, d[0], d[1], d[2], d[3], d[4], d[5], d[6], d[7], 1'b0};
        e.data    = d;
        e.ferr    = ~sb;
        e.cyc_exp = cyc + 3 + HALF + 10 * R;
        e.perr    = (pb != good_pb(d, 1'b1));
        q1.push_back(e);
        e.perr    = (pb != good_pb(d, 1'b0));
        q0.push_back(e);
        for (int i = 0; i < 11; i++) begin
            rx = bits[i];
            repeat (HALF) @(negedge clk);
            if (i == 5) begin
                chk("busy_mid_frame dut1", busy1, 1);
                chk("busy_mid_frame dut0", busy0, 1);
            end
            repeat (R - HALF) @(negedge clk);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " data_out dut1"}, do1, 8'h00);
        chk({tag, " data_out dut0"}, do0, 8'h00);
        chk({tag, " valid dut1"}, dv1, 0);
        chk({tag, " valid dut0"}, dv0, 0);
        chk({tag, " flags dut1"}, {pe1, fe1}, 0);
        chk({tag, " busy dut1"}, busy1, 0);
        chk({tag, " busy dut0"}, busy0, 0);
    endtask

    initial begin
        logic [7:0] b2b [3];
        logic [7:0] d;
        logic       pb, sb;
        logic [7:0] f1;

        b2b[0] = 8'hC0; b2b[1] = 8'h12; b2b[2] = 8'h8A;

        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b0;
        idle(R);

        // Good frame, correct odd parity.
        send_frame(8'hA5, 1'b1, 1'b1);
        idle(R);

        // Inverted parity bit.
        send_frame(8'h0F, 1'b0, 1'b1);
        idle(R);

        // Short glitch on the line, then a proper frame.
        rx = 1'b0;
        repeat (R / 4) @(negedge clk);
        idle(2 * R);
        chk("busy_after_glitch dut1", busy1, 0);
        chk("busy_after_glitch dut0", busy0, 0);
        send_frame(8'h3C, good_pb(8'h3C, 1'b1), 1'b1);
        idle(R);

        // Framing error followed by a held-low line.
        send_frame(8'h8A, good_pb(8'h8A, 1'b1), 1'b0);
        rx = 1'b0;
        repeat (3 * R) @(negedge clk);
        chk("busy_in_break dut1", busy1, 1);
        chk("busy_in_break dut0", busy0, 1);
        idle(R);
        chk("busy_after_break dut1", busy1, 0);
        send_frame(8'h11, good_pb(8'h11, 1'b1), 1'b1);
        idle(R);

        // Back-to-back frames with zero idle, parity chosen for each mode.
        for (int p = 1; p >= 0; p--) begin
            for (int i = 0; i < 3; i++) begin
                send_frame(b2b[i], good_pb(b2b[i], logic'(p)), 1'b1);
            end
            idle(R);
        end

        // Reset one cycle into the 5th data bit of 0xF1: frame abandoned.
        f1 = 8'hF1;
        rx = 1'b0;
        repeat (R) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = f1[7 - i];
            repeat (R) @(negedge clk);
        end
        rx = f1[3];
        @(negedge clk);
        rst = 1'b1;
        rx  = 1'b1;
        @(negedge clk);
        chk_reset_outputs("mid_frame_reset");
        rst = 1'b0;
        idle(2 * R);
        chk("busy_after_reset dut1", busy1, 0);
        send_frame(8'h5A, good_pb(8'h5A, 1'b1), 1'b1);
        idle(R);

        // Random frames: mostly good, some parity and framing errors.
        for (int n = 0; n < 30; n++) begin
            d  = 8'($urandom);
            pb = good_pb(d, 1'b1) ^ ($urandom_range(0, 4) == 0);
            sb = ($urandom_range(0, 6) != 0);
            send_frame(d, pb, sb);
            if (!sb) begin
                rx = 1'b0;
                repeat ($urandom_range(0, 2 * R)) @(negedge clk);
                idle($urandom_range(1, R));
            end else begin
                idle($urandom_range(0, HALF));
            end
        end

        idle(3 * R);
        chk("pending_expectations dut1", q1.size(), 0);
        chk("pending_expectations dut0", q0.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
